// File: rtl/rv32i_writeback_if.sv
// Writeback stage bundle: retiring instruction from MEM, data-memory response, register-file write.
// Latency: n/a (signal grouping only).
// Backpressure: o_stall (from writeback) holds the memory stage; no backpressure towards the register file.
interface rv32i_writeback_if;
   logic        i_ce;
   logic        o_stall;
   logic        i_wr_rd;
   logic [4:0]  i_rd_addr;
   logic [31:0] i_rd_result;
   logic        i_is_load;
   logic [2:0]  i_funct3;
   logic [1:0]  i_addr_lsb;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd;
   logic        o_wr_rd;
   logic        o_ce_write;
   logic        o_misaligned;

   // Writeback stage view.
   modport slave (
      input  i_ce, i_wr_rd, i_rd_addr, i_rd_result, i_is_load, i_funct3, i_addr_lsb, i_ack, i_rdata,
      output o_stall, o_rd_addr, o_rd, o_wr_rd, o_ce_write, o_misaligned
   );

   // Environment view (memory stage, data memory and register file combined).
   modport master (
      output i_ce, i_wr_rd, i_rd_addr, i_rd_result, i_is_load, i_funct3, i_addr_lsb, i_ack, i_rdata,
      input  o_stall, o_rd_addr, o_rd, o_wr_rd, o_ce_write, o_misaligned
   );
endinterface

// File: rtl/rv32i_writeback.sv
// rv32i stage-5 writeback: aligns/extends load data and issues one register-file write per instruction.
// Latency: 1 cycle from accept (non-load, or load with same-cycle ack) or from ack to the o_ce_write pulse.
// Backpressure: o_stall (combinational) is high while a load response is outstanding and i_ack is low.
// Optional feature macro: WB_MISALIGN_CHECK_EN (misaligned loads retire without a register update and
// pulse o_misaligned); when undefined o_misaligned is tied 0 and misaligned loads are written normally.
module rv32i_writeback (
   input  logic             i_clk,
   input  logic             i_rst_n,
   rv32i_writeback_if.slave wb
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_ACK = 1'b1;

   logic [0:0]  r_state;

   // Fields of the load waiting for its memory response.
   logic [4:0]  r_cap_rd_addr;
   logic        r_cap_wr_rd;
   logic [2:0]  r_cap_funct3;
   logic [1:0]  r_cap_lsb;

   // Registered register-file write port.
   logic        r_ce_write;
   logic        r_wr_rd;
   logic [4:0]  r_rd_addr;
   logic [31:0] r_rd;

   logic        w_in_wait;
   logic        w_retire_alu;
   logic        w_retire_load;
   logic        w_retire;
   logic        w_start_wait;
   logic [4:0]  w_sel_rd_addr;
   logic        w_sel_wr_rd;
   logic [2:0]  w_sel_funct3;
   logic [1:0]  w_sel_lsb;
   logic [31:0] w_load_data;
   logic        w_misaligned;

   // Byte/half/word selection with sign or zero extension; reserved encodings pass the full word.
   function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] d);
      logic [7:0]  v_byte;
      logic [15:0] v_half;
      logic [31:0] v_res;
      case (lsb)
         2'd0:    v_byte = d[7:0];
         2'd1:    v_byte = d[15:8];
         2'd2:    v_byte = d[23:16];
         default: v_byte = d[31:24];
      endcase
      v_half = lsb[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  v_res = {{24{v_byte[7]}}, v_byte};
         3'b100:  v_res = {24'd0, v_byte};
         3'b001:  v_res = {{16{v_half[15]}}, v_half};
         3'b101:  v_res = {16'd0, v_half};
         default: v_res = d;
      endcase
      return v_res;
   endfunction

   assign w_in_wait     = (r_state == S_WAIT_ACK);
   assign w_retire_alu  = !w_in_wait && wb.i_ce && !wb.i_is_load;
   assign w_retire_load = w_in_wait ? wb.i_ack : (wb.i_ce && wb.i_is_load && wb.i_ack);
   assign w_retire      = w_retire_alu || w_retire_load;
   assign w_start_wait  = !w_in_wait && wb.i_ce && wb.i_is_load && !wb.i_ack;

   // Upstream must hold while a load is accepted or outstanding without its response.
   assign wb.o_stall = w_in_wait ? !wb.i_ack : (wb.i_ce && wb.i_is_load && !wb.i_ack);

   // While waiting, the captured fields describe the retiring load; otherwise the live inputs do.
   always_comb begin
      w_sel_rd_addr = wb.i_rd_addr;
      w_sel_wr_rd   = wb.i_wr_rd;
      w_sel_funct3  = wb.i_funct3;
      w_sel_lsb     = wb.i_addr_lsb;
      if (w_in_wait) begin
         w_sel_rd_addr = r_cap_rd_addr;
         w_sel_wr_rd   = r_cap_wr_rd;
         w_sel_funct3  = r_cap_funct3;
         w_sel_lsb     = r_cap_lsb;
      end
   end

   assign w_load_data = f_extract(w_sel_funct3, w_sel_lsb, wb.i_rdata);

`ifdef WB_MISALIGN_CHECK_EN
   // Halfwords need lsb[0]==0, words need lsb==0.
   assign w_misaligned = ((w_sel_funct3[1:0] == 2'b01) && w_sel_lsb[0]) ||
                         ((w_sel_funct3 == 3'b010) && (w_sel_lsb != 2'b00));

   logic r_misaligned;

   // One-cycle flag alongside the retire pulse of a misaligned load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_misaligned <= 1'b0;
      else          r_misaligned <= w_retire_load && w_misaligned;
   end

   assign wb.o_misaligned = r_misaligned;
`else
   assign w_misaligned    = 1'b0;
   assign wb.o_misaligned = 1'b0;
`endif

   // FSM: park in WAIT_ACK while an accepted load has no response yet.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     if (w_start_wait) r_state <= S_WAIT_ACK;
            S_WAIT_ACK: if (wb.i_ack)     r_state <= S_IDLE;
            default:                      r_state <= S_IDLE;
         endcase
      end
   end

   // Capture destination and extraction controls of a load that must wait.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cap_rd_addr <= 5'd0;
         r_cap_wr_rd   <= 1'b0;
         r_cap_funct3  <= 3'd0;
         r_cap_lsb     <= 2'd0;
      end else if (w_start_wait) begin
         r_cap_rd_addr <= wb.i_rd_addr;
         r_cap_wr_rd   <= wb.i_wr_rd;
         r_cap_funct3  <= wb.i_funct3;
         r_cap_lsb     <= wb.i_addr_lsb;
      end
   end

   // Register-file write: pulse per retire; data/address hold between pulses; x0 never enabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ce_write <= 1'b0;
         r_wr_rd    <= 1'b0;
         r_rd_addr  <= 5'd0;
         r_rd       <= 32'd0;
      end else begin
         r_ce_write <= w_retire;
         if (w_retire) begin
            r_rd_addr <= w_sel_rd_addr;
            r_rd      <= w_retire_load ? w_load_data : wb.i_rd_result;
            r_wr_rd   <= w_sel_wr_rd && (w_sel_rd_addr != 5'd0) && !(w_retire_load && w_misaligned);
         end
      end
   end

   assign wb.o_ce_write = r_ce_write;
   assign wb.o_wr_rd    = r_wr_rd;
   assign wb.o_rd_addr  = r_rd_addr;
   assign wb.o_rd       = r_rd;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Scoreboard bench for rv32i_writeback: stimulus pushes expected writes, a monitor pops on each o_ce_write.
// Latency: checks the 1-cycle accept/ack-to-write relationship.
// Backpressure: o_stall checked directly by the stimulus each driven cycle.
module tb_rv32i_writeback;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic        w;
      logic        m;
      logic        chk_d;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   rv32i_writeback_if wb();

   rv32i_writeback dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .wb      (wb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [31:0] d, input logic w, input logic m,
                       input logic chk_d);
      exp_t e;
      e.a = a; e.d = d; e.w = w; e.m = m; e.chk_d = chk_d;
      sb.push_back(e);
   endtask

   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         wb.i_ce = 1'b0;
         wb.i_ack = 1'b0;
         wb.i_is_load = 1'b0;
         #1 check("stall_idle", {31'd0, wb.o_stall}, 32'd0);
      end
   endtask

   task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res, input logic wr,
                            input logic exp_wr);
      @(negedge clk);
      wb.i_ce = 1'b1;
      wb.i_is_load = 1'b0;
      wb.i_rd_addr = rd;
      wb.i_rd_result = res;
      wb.i_wr_rd = wr;
      wb.i_ack = 1'b0;
      push(rd, res, exp_wr, 1'b0, 1'b1);
      #1 check("stall_alu", {31'd0, wb.o_stall}, 32'd0);
   endtask

   // d = number of cycles o_stall is high before the ack cycle (0: ack with accept).
   task automatic issue_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] rdata,
                             input logic [4:0] rd, input logic wr, input int d,
                             input logic [31:0] exp_d, input logic exp_wr, input logic exp_m,
                             input logic chk_d);
      @(negedge clk);
      wb.i_ce = 1'b1;
      wb.i_is_load = 1'b1;
      wb.i_funct3 = f3;
      wb.i_addr_lsb = lsb;
      wb.i_rd_addr = rd;
      wb.i_wr_rd = wr;
      wb.i_rd_result = 32'h0BAD_0BAD;
      if (d == 0) begin
         wb.i_ack = 1'b1;
         wb.i_rdata = rdata;
         push(rd, exp_d, exp_wr, exp_m, chk_d);
         #1 check("stall_ack_now", {31'd0, wb.o_stall}, 32'd0);
      end else begin
         wb.i_ack = 1'b0;
         wb.i_rdata = 32'hFFFF_FFFF;
         #1 check("stall_accept", {31'd0, wb.o_stall}, 32'd1);
         for (int k = 1; k < d; k++) begin
            @(negedge clk);
            // Inputs change while waiting; the captured fields must win.
            wb.i_ce = k[0];
            wb.i_is_load = 1'b0;
            wb.i_rd_addr = 5'd31;
            wb.i_funct3 = 3'b010;
            wb.i_addr_lsb = 2'd0;
            wb.i_wr_rd = 1'b1;
            #1 check("stall_wait", {31'd0, wb.o_stall}, 32'd1);
         end
         @(negedge clk);
         wb.i_ack = 1'b1;
         wb.i_rdata = rdata;
         wb.i_ce = 1'b1;
         push(rd, exp_d, exp_wr, exp_m, chk_d);
         #1 check("stall_ack", {31'd0, wb.o_stall}, 32'd0);
      end
   endtask

   // Monitor: every write pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (wb.o_ce_write === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got o_ce_write=1 rd_addr=%0d rd=%h, required no write",
                        wb.o_rd_addr, wb.o_rd);
            end else begin
               e = sb.pop_front();
               check("rd_addr", {27'd0, wb.o_rd_addr}, {27'd0, e.a});
               check("wr_rd", {31'd0, wb.o_wr_rd}, {31'd0, e.w});
               check("misaligned", {31'd0, wb.o_misaligned}, {31'd0, e.m});
               if (e.chk_d) check("rd_data", wb.o_rd, e.d);
            end
         end else begin
            check("misaligned_no_pulse", {31'd0, wb.o_misaligned}, 32'd0);
         end
      end
   end

   initial begin
      logic mis;
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      wb.i_ce = 1'b0;
      wb.i_wr_rd = 1'b0;
      wb.i_rd_addr = 5'd0;
      wb.i_rd_result = 32'd0;
      wb.i_is_load = 1'b0;
      wb.i_funct3 = 3'd0;
      wb.i_addr_lsb = 2'd0;
      wb.i_ack = 1'b0;
      wb.i_rdata = 32'd0;
`ifdef WB_MISALIGN_CHECK_EN
      mis = 1'b1;
`else
      mis = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_ce_write", {31'd0, wb.o_ce_write}, 32'd0);
      check("rst_rd", wb.o_rd, 32'd0);
      check("rst_rd_addr", {27'd0, wb.o_rd_addr}, 32'd0);
      check("rst_wr_rd", {31'd0, wb.o_wr_rd}, 32'd0);
      check("rst_misaligned", {31'd0, wb.o_misaligned}, 32'd0);
      check("rst_stall", {31'd0, wb.o_stall}, 32'd0);
      rst_n = 1'b1;

      issue_alu(5'd5, 32'h0000_1234, 1'b1, 1'b1);
      bubble(1);
      issue_load(3'b000, 2'd2, 32'h0080_0000, 5'd7, 1'b1, 0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
      issue_load(3'b101, 2'd2, 32'hBEEF_0000, 5'd9, 1'b1, 3, 32'h0000_BEEF, 1'b1, 1'b0, 1'b1);
      issue_alu(5'd0, 32'h0000_DEAD, 1'b1, 1'b0);
      issue_load(3'b100, 2'd3, 32'h9A00_0000, 5'd10, 1'b1, 1, 32'h0000_009A, 1'b1, 1'b0, 1'b1);
      issue_load(3'b001, 2'd0, 32'h1234_8001, 5'd11, 1'b1, 0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1);
      issue_load(3'b010, 2'd0, 32'hCAFE_F00D, 5'd12, 1'b1, 2, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
      issue_load(3'b011, 2'd0, 32'h55AA_33CC, 5'd13, 1'b1, 0, 32'h55AA_33CC, 1'b1, 1'b0, 1'b1);
      issue_load(3'b000, 2'd1, 32'h0000_7F00, 5'd14, 1'b1, 1, 32'h0000_007F, 1'b1, 1'b0, 1'b1);
      issue_alu(5'd3, 32'hA5A5_5A5A, 1'b0, 1'b0);
      issue_load(3'b010, 2'd0, 32'h0F0F_F0F0, 5'd16, 1'b0, 0, 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b1);
      // Misaligned word and halfword loads.
      issue_load(3'b010, 2'd1, 32'h1122_3344, 5'd15, 1'b1, 1, 32'h1122_3344, !mis, mis, !mis);
      issue_load(3'b001, 2'd1, 32'hAABB_CCDD, 5'd17, 1'b1, 0, 32'hFFFF_CCDD, !mis, mis, !mis);
      // Stray ack with no instruction must not write.
      @(negedge clk);
      wb.i_ce = 1'b0;
      wb.i_ack = 1'b1;
      wb.i_rdata = 32'h7777_7777;
      bubble(2);

      // Reset while a load waits: pending load dropped, later ack ignored.
      @(negedge clk);
      wb.i_ce = 1'b1;
      wb.i_is_load = 1'b1;
      wb.i_funct3 = 3'b010;
      wb.i_addr_lsb = 2'd0;
      wb.i_rd_addr = 5'd20;
      wb.i_wr_rd = 1'b1;
      wb.i_ack = 1'b0;
      #1 check("stall_pre_reset", {31'd0, wb.o_stall}, 32'd1);
      @(negedge clk);
      wb.i_ce = 1'b0;
      #1 check("stall_wait_pre_reset", {31'd0, wb.o_stall}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("wrst_ce_write", {31'd0, wb.o_ce_write}, 32'd0);
      check("wrst_rd", wb.o_rd, 32'd0);
      check("wrst_rd_addr", {27'd0, wb.o_rd_addr}, 32'd0);
      check("wrst_wr_rd", {31'd0, wb.o_wr_rd}, 32'd0);
      check("wrst_stall", {31'd0, wb.o_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wb.i_ack = 1'b1;
      wb.i_rdata = 32'h1357_9BDF;
      #1 check("stall_post_reset", {31'd0, wb.o_stall}, 32'd0);
      @(posedge clk);
      #1 check("no_write_post_reset", {31'd0, wb.o_ce_write}, 32'd0);
      bubble(3);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
